// File: rtl/fdd_pkg.sv
// Shared types and sizing for the Disk II whole-track SD sequencer.
// A track is 13 SD sectors; LBAs are the track base plus the sector index.
package fdd_pkg;

   localparam int SECS   = 13;
   localparam int TRACKS = 35;
   localparam int LBA_W  = 32;

   typedef enum logic [2:0] {
      IDLE,
      WB_REQ,
      WB_ACK,
      RD_REQ,
      RD_ACK
   } fdd_st_t;

   typedef enum logic [1:0] {
      XF_IDLE,
      XF_REQ,
      XF_ACK
   } xfer_st_t;

   // track * 13 built from shifts so no multiplier is inferred
   function automatic logic [9:0] track_base(input logic [5:0] t);
      logic [9:0] t10;
      t10 = {4'b0, t};
      return (t10 << 3) + (t10 << 2) + t10;
   endfunction

   function automatic logic [LBA_W-1:0] sec_lba(input logic [9:0] b, input logic [3:0] s);
      return LBA_W'(b) + LBA_W'(s);
   endfunction

endpackage

// File: rtl/fdd_track_ctrl_if.sv
// SD sector channel between the track sequencer and hps_io.
interface fdd_track_ctrl_if;
   import fdd_pkg::*;

   logic [LBA_W-1:0] sd_lba;
   logic             sd_rd;
   logic             sd_wr;
   logic             sd_ack;

   modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
   modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);

endinterface

// File: rtl/sd_sector_xfer.sv
// One SD sector request/acknowledge handshake: request until ack rises,
// then wait for ack to fall and pulse done.
module sd_sector_xfer
   import fdd_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             is_wr,
   input  logic [LBA_W-1:0] lba,
   input  logic             sd_ack,
   output logic [LBA_W-1:0] sd_lba,
   output logic             sd_rd,
   output logic             sd_wr,
   output logic             acked,
   output logic             done
);

   xfer_st_t phase;
   logic     wr_q;
   logic     ack_q;
   logic     ack_rise;
   logic     ack_fall;

   assign ack_rise = sd_ack & ~ack_q;
   assign ack_fall = ~sd_ack & ack_q;

   assign sd_rd = (phase == XF_REQ) && !wr_q;
   assign sd_wr = (phase == XF_REQ) && wr_q;
   assign acked = (phase == XF_REQ) && ack_rise;
   assign done  = (phase == XF_ACK) && ack_fall;

   // A new start is taken on the done cycle, so the request gap is the ACK phase itself
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase  <= XF_IDLE;
         wr_q   <= 1'b0;
         ack_q  <= 1'b0;
         sd_lba <= '0;
      end else begin
         ack_q <= sd_ack;
         if (abort) begin
            phase <= XF_IDLE;
         end else if (start && (phase == XF_IDLE || done)) begin
            phase  <= XF_REQ;
            wr_q   <= is_wr;
            sd_lba <= lba;
         end else begin
            case (phase)
               XF_REQ:  if (ack_rise) phase <= XF_ACK;
               XF_ACK:  if (ack_fall) phase <= XF_IDLE;
               default: phase <= XF_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/fdd_track_ctrl.sv
// Whole-track loader for the Disk II buffer: writes back a dirty track, then
// reads the new one, 13 SD sectors each, stalling the CPU while it runs.
module fdd_track_ctrl
   import fdd_pkg::*;
(
   input  logic             clk_sys,
   input  logic             reset,
   input  logic [5:0]       track,
   input  logic             img_mounted,
   input  logic             img_present,
   input  logic             img_readonly,
   input  logic             buf_wr,
   fdd_track_ctrl_if.master sd,
   output logic [3:0]       buf_sec,
   output logic             cpu_wait,
   output logic             dirty
);

   fdd_st_t          state;
   fdd_st_t          state_next;
   logic [5:0]       cur_track;
   logic [5:0]       new_track;
   logic [9:0]       base;
   logic [9:0]       old_base;
   logic             cur_valid;
   logic             mounted;
   logic             wp;
   logic             reload;
   logic             abort_pend;
   logic             seq_en;
   logic             go;
   logic             wb_needed;
   logic             last_sec;
   logic             acked;
   logic             done;
   logic             acked_g;
   logic             done_g;
   logic             xfer_abort;
   logic             start;
   logic             start_wr;
   logic [LBA_W-1:0] start_lba;

   // A mount pulse or a pending abort freezes all sequencing for that cycle
   assign seq_en     = ~img_mounted & ~abort_pend;
   assign last_sec   = (buf_sec == 4'(SECS - 1));
   assign wb_needed  = dirty & cur_valid & ~wp;
   assign go         = seq_en && (state == IDLE) && mounted &&
                       (reload || (track != cur_track) || !cur_valid) &&
                       (track < 6'(TRACKS));
   assign acked_g    = acked & seq_en;
   assign done_g     = done & seq_en;
   assign xfer_abort = img_mounted | abort_pend;

   sd_sector_xfer u_xfer (
      .clk    (clk_sys),
      .reset  (reset),
      .start  (start),
      .abort  (xfer_abort),
      .is_wr  (start_wr),
      .lba    (start_lba),
      .sd_ack (sd.sd_ack),
      .sd_lba (sd.sd_lba),
      .sd_rd  (sd.sd_rd),
      .sd_wr  (sd.sd_wr),
      .acked  (acked),
      .done   (done)
   );

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (go)      state_next = wb_needed ? WB_REQ : RD_REQ;
         WB_REQ:  if (acked_g) state_next = WB_ACK;
         WB_ACK:  if (done_g)  state_next = last_sec ? RD_REQ : WB_REQ;
         RD_REQ:  if (acked_g) state_next = RD_ACK;
         RD_ACK:  if (done_g)  state_next = last_sec ? IDLE : RD_REQ;
         default: state_next = IDLE;
      endcase
      if (abort_pend && !sd.sd_ack) state_next = IDLE;
   end

   // Sector starts are issued on the transition into a *_REQ state
   always_comb begin
      start     = 1'b0;
      start_wr  = 1'b0;
      start_lba = '0;
      case (state)
         IDLE: begin
            if (go) begin
               start     = 1'b1;
               start_wr  = wb_needed;
               start_lba = wb_needed ? sec_lba(old_base, 4'd0)
                                     : sec_lba(track_base(track), 4'd0);
            end
         end
         WB_ACK: begin
            if (done_g) begin
               start = 1'b1;
               if (last_sec) begin
                  start_wr  = 1'b0;
                  start_lba = sec_lba(base, 4'd0);
               end else begin
                  start_wr  = 1'b1;
                  start_lba = sec_lba(old_base, buf_sec + 4'd1);
               end
            end
         end
         RD_ACK: begin
            if (done_g && !last_sec) begin
               start     = 1'b1;
               start_lba = sec_lba(base, buf_sec + 4'd1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         buf_sec    <= '0;
         cpu_wait   <= 1'b0;
         dirty      <= 1'b0;
         cur_track  <= '0;
         new_track  <= '0;
         base       <= '0;
         old_base   <= '0;
         cur_valid  <= 1'b0;
         mounted    <= 1'b0;
         wp         <= 1'b0;
         reload     <= 1'b0;
         abort_pend <= 1'b0;
      end else if (img_mounted) begin
         mounted   <= img_present;
         wp        <= img_readonly;
         dirty     <= 1'b0;
         cur_valid <= 1'b0;
         reload    <= 1'b1;
         if (state != IDLE) abort_pend <= 1'b1;
      end else if (abort_pend) begin
         if (!sd.sd_ack) begin
            abort_pend <= 1'b0;
            cpu_wait   <= 1'b0;
            buf_sec    <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  new_track <= track;
                  base      <= track_base(track);
                  buf_sec   <= '0;
                  cpu_wait  <= 1'b1;
                  reload    <= 1'b0;
               end else begin
                  if (!mounted || track >= 6'(TRACKS)) begin
                     cur_track <= track;
                     cur_valid <= 1'b0;
                  end
                  if (buf_wr && cur_valid && !wp) dirty <= 1'b1;
               end
            end
            WB_ACK: begin
               if (done_g) begin
                  if (last_sec) begin
                     buf_sec <= '0;
                     dirty   <= 1'b0;
                  end else begin
                     buf_sec <= buf_sec + 4'd1;
                  end
               end
            end
            RD_ACK: begin
               if (done_g) begin
                  if (last_sec) begin
                     cur_track <= new_track;
                     old_base  <= base;
                     cur_valid <= 1'b1;
                     cpu_wait  <= 1'b0;
                     buf_sec   <= '0;
                  end else begin
                     buf_sec <= buf_sec + 4'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fdd_track_ctrl.sv
// Bench for fdd_track_ctrl: an hps_io-like responder logs every sector request,
// and each test compares that log against the transfers it expects.
module tb_fdd_track_ctrl;
   import fdd_pkg::*;

   typedef struct packed {
      logic             rd;
      logic             wr;
      logic [LBA_W-1:0] lba;
      logic [3:0]       sec;
      logic             held;
   } xfer_t;

   logic       clk_sys = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] track = 6'd0;
   logic       img_mounted = 1'b0;
   logic       img_present = 1'b0;
   logic       img_readonly = 1'b0;
   logic       buf_wr = 1'b0;
   logic [3:0] buf_sec;
   logic       cpu_wait;
   logic       dirty;

   xfer_t exp_q[$];
   xfer_t obs_q[$];
   int    n_compared = 0;
   int    n_mismatched = 0;
   int    req_seen = 0;

   fdd_track_ctrl_if sd ();

   fdd_track_ctrl dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .track        (track),
      .img_mounted  (img_mounted),
      .img_present  (img_present),
      .img_readonly (img_readonly),
      .buf_wr       (buf_wr),
      .sd           (sd),
      .buf_sec      (buf_sec),
      .cpu_wait     (cpu_wait),
      .dirty        (dirty)
   );

   always #5 clk_sys = ~clk_sys;

   // Responder: random latency and ack length; "held" records whether the request was still up when ack dropped
   initial begin
      xfer_t t;
      sd.sd_ack = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (sd.sd_rd || sd.sd_wr) begin
            t.rd  = sd.sd_rd;
            t.wr  = sd.sd_wr;
            t.lba = sd.sd_lba;
            t.sec = buf_sec;
            req_seen++;
            repeat ($urandom_range(0, 3)) @(negedge clk_sys);
            sd.sd_ack = 1'b1;
            repeat ($urandom_range(1, 4)) @(negedge clk_sys);
            t.held = sd.sd_rd | sd.sd_wr;
            sd.sd_ack = 1'b0;
            obs_q.push_back(t);
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: still running at %0t, required finished", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic string fmt(input xfer_t x);
      return $sformatf("rd=%0b wr=%0b lba=%0d sec=%0d held=%0b", x.rd, x.wr, x.lba, x.sec, x.held);
   endfunction

   task automatic push_xfers(input bit wr, input int first_lba, input int n);
      xfer_t e;
      for (int i = 0; i < n; i++) begin
         e.rd   = !wr;
         e.wr   = wr;
         e.lba  = LBA_W'(first_lba + i);
         e.sec  = 4'(i);
         e.held = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   task automatic pop_pair(output xfer_t e, output xfer_t o, output bit have);
      have = (obs_q.size() > 0);
      e = exp_q.pop_front();
      o = have ? obs_q.pop_front() : '0;
   endtask

   task automatic pulse_mount(input logic present, input logic ro, input logic [5:0] trk);
      @(negedge clk_sys);
      track        = trk;
      img_present  = present;
      img_readonly = ro;
      img_mounted  = 1'b1;
      @(negedge clk_sys);
      img_mounted  = 1'b0;
   endtask

   task automatic wait_done(input int n_obs, input int budget, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk_sys);
         #1;
         if (obs_q.size() >= n_obs && cpu_wait === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit busy = 1'b0;
      repeat (3) @(negedge clk_sys);
      #1;
      n_compared++;
      if ({sd.sd_lba, sd.sd_rd, sd.sd_wr, buf_sec, cpu_wait, dirty} !== '0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_state: got lba=%0d rd=%0b wr=%0b sec=%0d wait=%0b dirty=%0b, want all 0",
                  sd.sd_lba, sd.sd_rd, sd.sd_wr, buf_sec, cpu_wait, dirty);
      end
      @(negedge clk_sys);
      reset = 1'b0;
      repeat (10) begin
         @(negedge clk_sys);
         if (cpu_wait || sd.sd_rd || sd.sd_wr) busy = 1'b1;
      end
      n_compared++;
      if (busy !== 1'b0 || obs_q.size() != 0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_no_mount: got activity=%0b xfers=%0d, want 0 and 0", busy, obs_q.size());
      end
   endtask

   task automatic test_mount_read();
      xfer_t e, o;
      bit have, ok;
      push_xfers(1'b0, 0, 13);
      pulse_mount(1'b1, 1'b0, 6'd0);
      wait_done(13, 2000, ok);
      n_compared++;
      if (!ok) begin n_mismatched++; $display("[TB] FAIL t1_done: got timeout, want sequence end"); end
      while (exp_q.size() > 0) begin
         pop_pair(e, o, have);
         n_compared++;
         if (!have || o !== e) begin
            n_mismatched++;
            $display("[TB] FAIL t1_xfer: got %s, want %s", have ? fmt(o) : "nothing", fmt(e));
         end
      end
      n_compared++;
      if (obs_q.size() != 0 || dirty !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL t1_tail: got extra=%0d dirty=%0b, want 0 and 0", obs_q.size(), dirty);
      end
   endtask

   task automatic test_writeback();
      xfer_t e, o;
      bit have, ok;
      @(negedge clk_sys);
      buf_wr = 1'b1;
      @(negedge clk_sys);
      buf_wr = 1'b0;
      #1;
      n_compared++;
      if (dirty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL t2_dirty_set: got %0b, want 1", dirty); end
      push_xfers(1'b1, 0, 13);
      push_xfers(1'b0, 65, 13);
      track = 6'd5;
      wait_done(26, 4000, ok);
      n_compared++;
      if (!ok) begin n_mismatched++; $display("[TB] FAIL t2_done: got timeout, want sequence end"); end
      while (exp_q.size() > 0) begin
         pop_pair(e, o, have);
         n_compared++;
         if (!have || o !== e) begin
            n_mismatched++;
            $display("[TB] FAIL t2_xfer: got %s, want %s", have ? fmt(o) : "nothing", fmt(e));
         end
      end
      n_compared++;
      if (obs_q.size() != 0 || dirty !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL t2_tail: got extra=%0d dirty=%0b, want 0 and 0", obs_q.size(), dirty);
      end
   endtask

   task automatic test_readonly();
      xfer_t e, o;
      bit have, ok;
      push_xfers(1'b0, 0, 13);
      pulse_mount(1'b1, 1'b1, 6'd0);
      wait_done(13, 2000, ok);
      @(negedge clk_sys);
      buf_wr = 1'b1;
      @(negedge clk_sys);
      buf_wr = 1'b0;
      #1;
      n_compared++;
      if (!ok || dirty !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL t3_wp_dirty: got done=%0b dirty=%0b, want 1 and 0", ok, dirty);
      end
      push_xfers(1'b0, 65, 13);
      track = 6'd5;
      wait_done(26 - 13 + obs_q.size(), 2000, ok);
      n_compared++;
      if (!ok) begin n_mismatched++; $display("[TB] FAIL t3_done: got timeout, want sequence end"); end
      while (exp_q.size() > 0) begin
         pop_pair(e, o, have);
         n_compared++;
         if (!have || o !== e) begin
            n_mismatched++;
            $display("[TB] FAIL t3_xfer: got %s, want %s", have ? fmt(o) : "nothing", fmt(e));
         end
      end
      n_compared++;
      if (obs_q.size() != 0) begin n_mismatched++; $display("[TB] FAIL t3_tail: got extra=%0d, want 0", obs_q.size()); end
   endtask

   task automatic test_bad_track();
      xfer_t e, o;
      bit have, ok;
      bit busy = 1'b0;
      track = 6'd36;
      repeat (40) begin
         @(negedge clk_sys);
         if (cpu_wait || sd.sd_rd || sd.sd_wr) busy = 1'b1;
      end
      n_compared++;
      if (busy !== 1'b0 || obs_q.size() != 0) begin
         n_mismatched++;
         $display("[TB] FAIL t4_track36: got activity=%0b xfers=%0d, want 0 and 0", busy, obs_q.size());
      end
      push_xfers(1'b0, 442, 13);
      track = 6'd34;
      wait_done(13, 2000, ok);
      n_compared++;
      if (!ok) begin n_mismatched++; $display("[TB] FAIL t4_done: got timeout, want sequence end"); end
      while (exp_q.size() > 0) begin
         pop_pair(e, o, have);
         n_compared++;
         if (!have || o !== e) begin
            n_mismatched++;
            $display("[TB] FAIL t4_xfer: got %s, want %s", have ? fmt(o) : "nothing", fmt(e));
         end
      end
      n_compared++;
      if (obs_q.size() != 0) begin n_mismatched++; $display("[TB] FAIL t4_tail: got extra=%0d, want 0", obs_q.size()); end
   endtask

   task automatic test_reset_mid();
      xfer_t e, o;
      bit have, ok;
      bit hit = 1'b0;
      int start_cnt;
      push_xfers(1'b0, 442, 7);
      start_cnt = req_seen;
      pulse_mount(1'b1, 1'b0, 6'd34);
      for (int n = 0; n < 2000 && !hit; n++) begin
         @(negedge clk_sys);
         #1;
         if (req_seen >= start_cnt + 7 && sd.sd_ack) hit = 1'b1;
      end
      n_compared++;
      if (!hit || cpu_wait !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL t5_busy_before: got hit=%0b wait=%0b, want 1 and 1", hit, cpu_wait);
      end
      reset = 1'b1;
      #1;
      n_compared++;
      if ({sd.sd_rd, sd.sd_wr, cpu_wait, buf_sec, dirty} !== '0) begin
         n_mismatched++;
         $display("[TB] FAIL t5_async: got rd=%0b wr=%0b wait=%0b sec=%0d dirty=%0b, want all 0",
                  sd.sd_rd, sd.sd_wr, cpu_wait, buf_sec, dirty);
      end
      repeat (3) @(negedge clk_sys);
      reset = 1'b0;
      hit = 1'b0;
      for (int n = 0; n < 100 && !hit; n++) begin
         @(negedge clk_sys);
         #1;
         if (!sd.sd_ack) hit = 1'b1;
      end
      while (exp_q.size() > 0) begin
         pop_pair(e, o, have);
         n_compared++;
         if (!have || o !== e) begin
            n_mismatched++;
            $display("[TB] FAIL t5_partial: got %s, want %s", have ? fmt(o) : "nothing", fmt(e));
         end
      end
      push_xfers(1'b0, 442, 13);
      pulse_mount(1'b1, 1'b0, 6'd34);
      wait_done(13, 2000, ok);
      n_compared++;
      if (!ok || obs_q.size() != 13) begin
         n_mismatched++;
         $display("[TB] FAIL t5_reload_count: got done=%0b xfers=%0d, want 1 and 13", ok, obs_q.size());
      end
      while (exp_q.size() > 0) begin
         pop_pair(e, o, have);
         n_compared++;
         if (!have || o !== e) begin
            n_mismatched++;
            $display("[TB] FAIL t5_xfer: got %s, want %s", have ? fmt(o) : "nothing", fmt(e));
         end
      end
   endtask

   task automatic test_back_to_back();
      xfer_t e, o;
      bit have, ok;
      bit hit = 1'b0;
      int start_cnt;
      obs_q.delete();
      push_xfers(1'b0, 39, 13);
      push_xfers(1'b0, 52, 13);
      start_cnt = req_seen;
      track = 6'd3;
      for (int n = 0; n < 2000 && !hit; n++) begin
         @(negedge clk_sys);
         #1;
         if (req_seen >= start_cnt + 4) hit = 1'b1;
      end
      track = 6'd4;
      wait_done(26, 4000, ok);
      n_compared++;
      if (!hit || !ok) begin
         n_mismatched++;
         $display("[TB] FAIL t6_done: got mid=%0b done=%0b, want 1 and 1", hit, ok);
      end
      while (exp_q.size() > 0) begin
         pop_pair(e, o, have);
         n_compared++;
         if (!have || o !== e) begin
            n_mismatched++;
            $display("[TB] FAIL t6_xfer: got %s, want %s", have ? fmt(o) : "nothing", fmt(e));
         end
      end
      n_compared++;
      if (obs_q.size() != 0 || cpu_wait !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL t6_tail: got extra=%0d wait=%0b, want 0 and 0", obs_q.size(), cpu_wait);
      end
   endtask

   initial begin
      $display("[TB] start");
      test_reset();
      test_mount_read();
      test_writeback();
      test_readonly();
      test_bad_track();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
